// File: rtl/food_spawner_pkg.sv
// rtl/food_spawner_pkg.sv - shared constants, FSM state type and LFSR tap table for the food spawner
package food_spawner_pkg;

    localparam int DEFAULT_GRID_WIDTH  = 32;
    localparam int DEFAULT_GRID_HEIGHT = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_CHECK,
        ST_SCAN_Q,
        ST_SCAN_C
    } state_t;

    // Maximal-length right-shift Galois taps for the supported register widths.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            default: return 32'h8020_0003;
        endcase
    endfunction

endpackage

// File: rtl/food_spawner_lfsr_galois.sv
// rtl/food_spawner_lfsr_galois.sv - free-running right-shift Galois LFSR with zero-seed guard
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [WIDTH-1:0] State
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [WIDTH-1:0] INIT = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            State <= INIT;
        end else begin
            State <= (State >> 1) ^ (State[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - random-then-scan food placement engine for the snake grid
module food_spawner
    import food_spawner_pkg::*;
#(
    parameter int                    GRID_WIDTH  = DEFAULT_GRID_WIDTH,
    parameter int                    GRID_HEIGHT = DEFAULT_GRID_HEIGHT,
    parameter int                    LFSR_WIDTH  = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED        = 16'hACE1,
    parameter int                    MAX_TRIES   = 8,
    localparam int                   XW          = $clog2(GRID_WIDTH),
    localparam int                   YW          = $clog2(GRID_HEIGHT)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Request,
    input  logic          Occupied,
    output logic [XW-1:0] QueryX,
    output logic [YW-1:0] QueryY,
    output logic [XW-1:0] xCoord,
    output logic [YW-1:0] yCoord,
    output logic          Valid,
    output logic          Fail,
    output logic          Busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = $clog2(GRID_WIDTH * GRID_HEIGHT + 1);

    localparam logic [XW:0]   X_LIM   = (XW+1)'(GRID_WIDTH);
    localparam logic [YW:0]   Y_LIM   = (YW+1)'(GRID_HEIGHT);
    localparam logic [XW-1:0] X_LAST  = XW'(GRID_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(GRID_HEIGHT - 1);
    localparam logic [TW-1:0] TRY_LIM = TW'(MAX_TRIES);
    localparam logic [CW-1:0] CELLS   = CW'(GRID_WIDTH * GRID_HEIGHT);

    logic [LFSR_WIDTH-1:0] lfsr_state;

    state_t        state,    state_nxt;
    logic [TW-1:0] tries,    tries_nxt;
    logic [CW-1:0] scan_cnt, scan_cnt_nxt;
    logic [XW-1:0] ptr_x,    ptr_x_nxt;
    logic [YW-1:0] ptr_y,    ptr_y_nxt;
    logic [XW-1:0] query_x_nxt, x_coord_nxt;
    logic [YW-1:0] query_y_nxt, y_coord_nxt;
    logic          valid_nxt, fail_nxt;

    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic          cand_ok;
    logic [TW-1:0] tries_inc;
    logic [CW-1:0] scan_cnt_inc;

    lfsr_galois #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (SEED),
        .TAPS  (LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH)))
    ) u_lfsr (
        .Clock (Clock),
        .Reset (Reset),
        .State (lfsr_state)
    );

    // Bits above the candidate field only shape the sequence.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_state;

    function automatic logic [XW+YW-1:0] succ_cell(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [XW-1:0] nx;
        logic [YW-1:0] ny;
        nx = x + XW'(1);
        ny = y;
        if (x == X_LAST) begin
            nx = '0;
            ny = (y == Y_LAST) ? '0 : y + YW'(1);
        end
        return {ny, nx};
    endfunction

    assign cand_x       = lfsr_state[XW-1:0];
    assign cand_y       = lfsr_state[XW+YW-1:XW];
    assign cand_ok      = ({1'b0, cand_x} < X_LIM) && ({1'b0, cand_y} < Y_LIM);
    assign tries_inc    = tries + TW'(1);
    assign scan_cnt_inc = scan_cnt + CW'(1);
    assign Busy         = (state != ST_IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            tries    <= '0;
            scan_cnt <= '0;
            ptr_x    <= '0;
            ptr_y    <= '0;
            QueryX   <= '0;
            QueryY   <= '0;
            xCoord   <= '0;
            yCoord   <= '0;
            Valid    <= 1'b0;
            Fail     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tries    <= tries_nxt;
            scan_cnt <= scan_cnt_nxt;
            ptr_x    <= ptr_x_nxt;
            ptr_y    <= ptr_y_nxt;
            QueryX   <= query_x_nxt;
            QueryY   <= query_y_nxt;
            xCoord   <= x_coord_nxt;
            yCoord   <= y_coord_nxt;
            Valid    <= valid_nxt;
            Fail     <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tries_nxt    = tries;
        scan_cnt_nxt = scan_cnt;
        ptr_x_nxt    = ptr_x;
        ptr_y_nxt    = ptr_y;
        query_x_nxt  = QueryX;
        query_y_nxt  = QueryY;
        x_coord_nxt  = xCoord;
        y_coord_nxt  = yCoord;
        valid_nxt    = 1'b0;
        fail_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Request) begin
                    tries_nxt = '0;
                    state_nxt = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (cand_ok) begin
                    query_x_nxt = cand_x;
                    query_y_nxt = cand_y;
                    state_nxt   = ST_CHECK;
                end else begin
                    tries_nxt = tries_inc;
                    if (tries_inc == TRY_LIM) begin
                        ptr_x_nxt    = '0;
                        ptr_y_nxt    = '0;
                        scan_cnt_nxt = '0;
                        state_nxt    = ST_SCAN_Q;
                    end
                end
            end
            ST_CHECK: begin
                if (!Occupied) begin
                    x_coord_nxt = QueryX;
                    y_coord_nxt = QueryY;
                    valid_nxt   = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    tries_nxt = tries_inc;
                    if (tries_inc == TRY_LIM) begin
                        // Scan resumes just past the last rejected cell.
                        {ptr_y_nxt, ptr_x_nxt} = succ_cell(QueryX, QueryY);
                        scan_cnt_nxt           = '0;
                        state_nxt              = ST_SCAN_Q;
                    end else begin
                        state_nxt = ST_DRAW;
                    end
                end
            end
            ST_SCAN_Q: begin
                query_x_nxt = ptr_x;
                query_y_nxt = ptr_y;
                state_nxt   = ST_SCAN_C;
            end
            ST_SCAN_C: begin
                if (!Occupied) begin
                    x_coord_nxt = QueryX;
                    y_coord_nxt = QueryY;
                    valid_nxt   = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    {ptr_y_nxt, ptr_x_nxt} = succ_cell(ptr_x, ptr_y);
                    scan_cnt_nxt           = scan_cnt_inc;
                    if (scan_cnt_inc == CELLS) begin
                        fail_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_SCAN_Q;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_food_spawner.sv
// tb/tb_food_spawner.sv - directed self-checking bench for food_spawner at the default 32x24 grid
module tb_food_spawner;

    localparam int W     = 32;
    localparam int H     = 24;
    localparam int TRIES = 8;
    localparam logic [15:0] SEED_V = 16'hACE1;
    localparam logic [15:0] TAPS_V = 16'hB400;

    logic       Clock;
    logic       Reset;
    logic       Request;
    logic       Occupied;
    logic [4:0] QueryX;
    logic [4:0] QueryY;
    logic [4:0] xCoord;
    logic [4:0] yCoord;
    logic       Valid;
    logic       Fail;
    logic       Busy;

    int total = 0;
    int bad   = 0;
    int occ_mode = 0;
    int last_x = 0;
    int last_y = 0;
    logic [15:0] mdl;
    bit col_hit [W];
    bit row_hit [H];

    food_spawner dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Request  (Request),
        .Occupied (Occupied),
        .QueryX   (QueryX),
        .QueryY   (QueryY),
        .xCoord   (xCoord),
        .yCoord   (yCoord),
        .Valid    (Valid),
        .Fail     (Fail),
        .Busy     (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ TAPS_V;
        return n;
    endfunction

    always @(posedge Clock) begin
        if (Reset) mdl <= SEED_V;
        else       mdl <= lfsr_step(mdl);
    end

    function automatic bit is_occ(input int x, input int y);
        case (occ_mode)
            0:       return 1'b0;
            1:       return !(x == 5 && y == 7);
            default: return 1'b1;
        endcase
    endfunction

    // Combinational store view: answers the registered query in the following cycle.
    always_comb begin
        Occupied = is_occ(int'(QueryX), int'(QueryY));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts the Request cycle as 0; s0 is the LFSR value in the first DRAW cycle.
    task automatic predict(input logic [15:0] s0, output int ex, output int ey,
                           output int efail, output int elat);
        logic [15:0] s;
        int x, y, px, py, tries, lat;
        bit found;
        s = s0; lat = 1; tries = 0; found = 0; px = 0; py = 0;
        ex = last_x; ey = last_y; efail = 1;
        while (!found && tries < TRIES) begin
            x = int'(s[4:0]);
            y = int'(s[9:5]);
            if (x < W && y < H) begin
                lat += 2;
                if (!is_occ(x, y)) begin
                    found = 1; ex = x; ey = y; efail = 0;
                end else begin
                    s = lfsr_step(lfsr_step(s));
                    tries++;
                    px = (x == W - 1) ? 0 : x + 1;
                    py = (x == W - 1) ? ((y == H - 1) ? 0 : y + 1) : y;
                end
            end else begin
                lat += 1;
                s = lfsr_step(s);
                tries++;
                px = 0; py = 0;
            end
        end
        for (int n = 0; n < W * H && !found; n++) begin
            lat += 2;
            if (!is_occ(px, py)) begin
                found = 1; ex = px; ey = py; efail = 0;
            end else if (px == W - 1) begin
                px = 0;
                py = (py == H - 1) ? 0 : py + 1;
            end else begin
                px = px + 1;
            end
        end
        elat = lat;
    endtask

    task automatic run_placement(input string tag);
        int ex, ey, efail, elat, cyc;
        Request = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Request = 1'b0;
        cyc = 1;
        predict(mdl, ex, ey, efail, elat);
        while (!(Valid || Fail) && cyc < 3000) begin
            @(negedge Clock);
            cyc++;
        end
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_valid"}, Valid, (efail == 0));
        check({tag, "_fail"}, Fail, efail);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_xy"}, {xCoord, yCoord}, {ex[4:0], ey[4:0]});
        if (efail == 0) begin
            last_x = ex;
            last_y = ey;
            if (ex < W) col_hit[ex] = 1'b1;
            if (ey < H) row_hit[ey] = 1'b1;
        end
    endtask

    initial begin
        int ncol, nrow, nvalid, starts, extra;
        bit prev_busy;
        Reset = 1'b1;
        Request = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_x", xCoord, 0);
        check("rst_y", yCoord, 0);
        check("rst_qx", QueryX, 0);
        check("rst_qy", QueryY, 0);
        check("rst_pulses", {Valid, Fail, Busy}, 3'b000);

        occ_mode = 0;
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            run_placement("empty");
        end
        ncol = 0;
        nrow = 0;
        foreach (col_hit[i]) ncol += int'(col_hit[i]);
        foreach (row_hit[i]) nrow += int'(row_hit[i]);
        check("cols_hit", ncol, W);
        check("rows_hit", nrow, H);
        check("col31_hit", col_hit[W-1], 1);
        check("row23_hit", row_hit[H-1], 1);

        // Request held through several placements: each start yields one Valid, nothing queued.
        @(negedge Clock);
        nvalid = 0; starts = 0; prev_busy = Busy;
        Request = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (Valid) begin
                nvalid++;
                check("held_busy_on_valid", Busy, 0);
            end
            if (Busy && !prev_busy) starts++;
            prev_busy = Busy;
        end
        Request = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Valid) nvalid++;
            if (Busy && !prev_busy) starts++;
            prev_busy = Busy;
        end
        check("held_one_valid_per_start", nvalid, starts);
        check("held_started", (starts >= 2), 1);
        check("held_idle_after", Busy, 0);

        run_placement("resync");

        occ_mode = 1;
        run_placement("scan");
        check("scan_xy_5_7", {xCoord, yCoord}, {5'd5, 5'd7});

        occ_mode = 2;
        run_placement("full");
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (Fail || Valid) extra++;
        end
        check("full_single_pulse", extra, 0);
        check("full_keeps_xy", {xCoord, yCoord}, {5'd5, 5'd7});

        // Reset in the middle of a scan aborts silently.
        Request = 1'b1;
        @(negedge Clock);
        Request = 1'b0;
        repeat (60) @(negedge Clock);
        check("midscan_busy", Busy, 1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("mrst_x", xCoord, 0);
        check("mrst_y", yCoord, 0);
        check("mrst_q", {QueryX, QueryY}, 0);
        check("mrst_pulses", {Valid, Fail, Busy}, 3'b000);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (Fail || Valid || Busy) extra++;
        end
        check("mrst_quiet", extra, 0);
        occ_mode = 0;
        run_placement("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
